led_seq_wbm: RTL and testbench

Wishbone master that drives the 4-bit LED register slave on the BeagleWire fabric. It generates LED patterns autonomously: static, blink, rotate and bounce. Patterns advance at a programmable rate derived from a clock prescaler. Each new pattern is written to the slave at address 0 through a single-beat write FSM, with ack timeout detection.

---
 rtl/led_seq_wbm.sv | 204 ++++++++++++++++++++
 tb/tb_led_seq_wbm.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_seq_wbm.sv
// led_seq_wbm: autonomous LED pattern sequencer acting as a single-beat
// Wishbone master towards the 4-bit LED register slave (address 0).
//
// Ports:
//   clk, reset        system clock; synchronous active-low reset
//   enable            sequencer run enable (level)
//   mode              0=static, 1=blink, 2=rotate-left, 3=bounce
//   period            base ticks per pattern step (0 behaves as 1)
//   pattern           seed / static pattern
//   wbm_address       always 0
//   wbm_writedata     {zeros, 4-bit pattern being written}
//   wbm_write         write strobe, high together with wbm_cycle
//   wbm_cycle         bus cycle in progress
//   wbm_ack           slave acknowledge (only looked at while waiting)
//   cur_leds          last pattern acknowledged by the slave
//   busy              write FSM not idle
//   err               sticky ack-timeout flag, cleared only by reset
module led_seq_wbm #(
  parameter int unsigned CLK_DIV     = 100000,
  parameter int unsigned ADDR_WIDTH  = 1,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [7:0]            period,
  input  logic [3:0]            pattern,
  output logic [ADDR_WIDTH-1:0] wbm_address,
  output logic [DATA_WIDTH-1:0] wbm_writedata,
  output logic                  wbm_write,
  output logic                  wbm_cycle,
  input  logic                  wbm_ack,
  output logic [3:0]            cur_leds,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned   PW         = $clog2(CLK_DIV);
  localparam int unsigned   TW         = $clog2(ACK_TIMEOUT + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state, state_nxt;

  logic [PW-1:0] presc;
  logic [7:0]    step_cnt;
  logic [7:0]    eff_period;
  logic          en_d, rise, fall, tick, step;
  logic [1:0]    last_mode;
  logic          mode_new;
  logic          blink_off, bounce_up;
  logic          nxt_blink_off, nxt_bounce_up, dir_up;
  logic [3:0]    nxt, seed, rot_seed;
  logic          pend;
  logic [3:0]    pend_data;
  logic [3:0]    data_q, cur_q;
  logic [TW-1:0] timer;
  logic          err_q;
  logic          start, ack_done, timeout;

  assign rise       = enable & ~en_d;
  assign fall       = ~enable & en_d;
  assign tick       = enable && (presc == PRESC_LAST);
  assign eff_period = (period == 8'd0) ? 8'd1 : period;
  // 9-bit compare so a period lowered below the running count still fires.
  assign step       = tick && (({1'b0, step_cnt} + 9'd1) >= {1'b0, eff_period});
  assign mode_new   = (mode != last_mode);

  // Value written immediately on the enable rising edge.
  always_comb begin
    rot_seed = (pattern == 4'd0) ? 4'b0001 : pattern;
    case (mode)
      2'd2:    seed = rot_seed;
      2'd3:    seed = 4'b0001;
      default: seed = pattern;
    endcase
  end

  // Next pattern on a step; a mode change restarts blink phase / bounce direction.
  always_comb begin
    nxt           = '0;
    nxt_blink_off = blink_off;
    nxt_bounce_up = bounce_up;
    dir_up        = mode_new ? 1'b1 : bounce_up;
    case (mode)
      2'd0: nxt = pattern;
      2'd1: begin
        if (mode_new || !blink_off) begin
          nxt           = pattern;
          nxt_blink_off = 1'b1;
        end else begin
          nxt           = 4'b0000;
          nxt_blink_off = 1'b0;
        end
      end
      2'd2: nxt = (cur_q == 4'd0) ? rot_seed : {cur_q[2:0], cur_q[3]};
      2'd3: begin
        nxt_bounce_up = dir_up;
        case (cur_q)
          4'b0001: begin nxt = 4'b0010; nxt_bounce_up = 1'b1; end
          4'b0010: nxt = dir_up ? 4'b0100 : 4'b0001;
          4'b0100: nxt = dir_up ? 4'b1000 : 4'b0010;
          4'b1000: begin nxt = 4'b0100; nxt_bounce_up = 1'b0; end
          default: begin nxt = 4'b0001; nxt_bounce_up = 1'b1; end
        endcase
      end
      default: nxt = pattern;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc     <= '0;
      step_cnt  <= '0;
      en_d      <= 1'b0;
      pend      <= 1'b0;
      pend_data <= '0;
      blink_off <= 1'b0;
      bounce_up <= 1'b1;
      last_mode <= '0;
    end else begin
      en_d <= enable;
      if (!enable || presc == PRESC_LAST) presc <= '0;
      else                                presc <= presc + PW'(1);
      if (!enable)   step_cnt <= '0;
      else if (tick) step_cnt <= step ? 8'd0 : step_cnt + 8'd1;
      // A new value arriving in the same cycle as the FSM latches the old
      // one keeps pend set: single-entry, newest-wins pending slot.
      if (start) pend <= 1'b0;
      if (rise) begin
        pend      <= 1'b1;
        pend_data <= seed;
        blink_off <= 1'b1;
        bounce_up <= 1'b1;
        last_mode <= mode;
      end else if (fall) begin
        pend      <= 1'b1;
        pend_data <= 4'b0000;
      end else if (step) begin
        pend      <= 1'b1;
        pend_data <= nxt;
        blink_off <= nxt_blink_off;
        bounce_up <= nxt_bounce_up;
        last_mode <= mode;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    ack_done  = 1'b0;
    timeout   = 1'b0;
    case (state)
      S_IDLE: if (pend) begin
        start     = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: if (wbm_ack) begin
        ack_done  = 1'b1;
        state_nxt = S_IDLE;
      end else if (timer == TIMER_LAST) begin
        timeout   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q <= '0;
      timer  <= '0;
      cur_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (start)                 begin data_q <= pend_data; timer <= '0; end
      else if (state == S_WAIT)  timer <= timer + TW'(1);
      if (ack_done) cur_q <= data_q;
      if (timeout)  err_q <= 1'b1;
    end
  end

  always_comb begin
    wbm_writedata      = '0;
    wbm_writedata[3:0] = data_q;
  end

  assign wbm_address = '0;
  assign wbm_cycle   = (state == S_WAIT);
  assign wbm_write   = (state == S_WAIT);
  assign busy        = (state != S_IDLE);
  assign cur_leds    = cur_q;
  assign err         = err_q;

endmodule

// File: tb/tb_led_seq_wbm.sv
// Testbench for led_seq_wbm: randomized and directed phases, expected bus
// writes queued by the stimulus from a pattern-rule model, popped and
// compared by an independent bus monitor.
module tb_led_seq_wbm;
  localparam int CLK_DIV     = 4;
  localparam int ACK_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  period = 8'd2;
  logic [3:0]  pattern = 4'd0;
  logic [0:0]  wbm_address;
  logic [15:0] wbm_writedata;
  logic        wbm_write, wbm_cycle;
  logic        wbm_ack = 1'b0;
  logic [3:0]  cur_leds;
  logic        busy, err;

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q[$];
  int ack_delay = 0;
  bit idle_noise = 1'b0;

  led_seq_wbm #(.CLK_DIV(CLK_DIV), .ADDR_WIDTH(1), .DATA_WIDTH(16), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .period(period),
    .pattern(pattern), .wbm_address(wbm_address), .wbm_writedata(wbm_writedata),
    .wbm_write(wbm_write), .wbm_cycle(wbm_cycle), .wbm_ack(wbm_ack),
    .cur_leds(cur_leds), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Pattern written at position k of a run (k=0 is the enable seed).
  function automatic logic [3:0] model_val(input logic [1:0] m, input logic [3:0] pat, input int k);
    logic [7:0] dbl;
    logic [3:0] s;
    int pos;
    case (m)
      2'd0: return pat;
      2'd1: return (k % 2 == 0) ? pat : 4'h0;
      2'd2: begin
        s   = (pat == 4'h0) ? 4'h1 : pat;
        dbl = {s, s} >> (4 - (k % 4));
        return dbl[3:0];
      end
      default: begin
        pos = k % 6;
        if (pos > 3) pos = 6 - pos;
        return 4'(1 << pos);
      end
    endcase
  endfunction

  // Slave: acks after ack_delay cycles of an open bus cycle; optional noise while idle.
  int scnt = 0;
  int sdelay = 0;
  always @(negedge clk) begin
    if (wbm_cycle) begin
      if (scnt == 0) sdelay = ack_delay;
      wbm_ack = (scnt >= sdelay);
      scnt++;
    end else begin
      scnt = 0;
      wbm_ack = idle_noise ? 1'($urandom % 2) : 1'b0;
    end
  end

  // Monitor: sampled just after each rising edge.
  logic       prev_cyc = 1'b0;
  logic [3:0] wr_data = 4'h0;
  logic [3:0] cur_before = 4'h0;
  int         cyc_len = 0;
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      prev_cyc = 1'b0;
      cyc_len  = 0;
    end else begin
      if (prev_cyc) begin
        if (wbm_ack) begin
          check("release_after_ack", wbm_cycle, 0);
          check("cur_leds_after_ack", cur_leds, wr_data);
          check("busy_after_ack", busy, 0);
        end else if (!wbm_cycle) begin
          check("timeout_length", cyc_len, ACK_TIMEOUT);
          check("err_after_timeout", err, 1);
          check("cur_leds_after_timeout", cur_leds, cur_before);
          check("write_drop", wbm_write, 0);
        end else begin
          cyc_len++;
          check("data_stable", wbm_writedata, {12'h0, wr_data});
          check("write_with_cycle", wbm_write, 1);
        end
      end
      if (wbm_cycle && !prev_cyc) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write actual=%0h required=none", wbm_writedata);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          check("write_data", wbm_writedata, {12'h0, e});
        end
        check("address", wbm_address, 0);
        check("write_strobe", wbm_write, 1);
        check("busy_in_cycle", busy, 1);
        wr_data    = wbm_writedata[3:0];
        cur_before = cur_leds;
        cyc_len    = 1;
      end
      prev_cyc = wbm_cycle;
    end
  end

  task automatic do_reset();
    enable = 1'b0;
    reset  = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("rst_cycle", wbm_cycle, 0);
    check("rst_write", wbm_write, 0);
    check("rst_addr", wbm_address, 0);
    check("rst_data", wbm_writedata, 0);
    check("rst_cur", cur_leds, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain_and_idle(input bit exp_err);
    int n;
    for (int i = 0; i < 100 && (exp_q.size() != 0 || wbm_cycle || busy); i++) @(negedge clk);
    check("all_writes_seen", exp_q.size(), 0);
    check("final_err", err, exp_err);
    check("final_cur", cur_leds, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wbm_cycle) n++;
    end
    check("no_cycles_after_stop", n, 0);
  endtask

  task automatic run_phase(input logic [1:0] m, input logic [7:0] p, input logic [3:0] pat,
                           input int dly, input int nsteps, input bit never_ack);
    int pe, first, wait_n;
    pe = (p == 8'd0) ? 1 : int'(p);
    do_reset();
    mode = m; period = p; pattern = pat;
    ack_delay = never_ack ? 1000 : dly;
    for (int k = 0; k <= nsteps; k++) exp_q.push_back(model_val(m, pat, k));
    exp_q.push_back(4'h0);
    enable = 1'b1;
    first  = -1;
    // Half a step interval past the last step, so exactly nsteps steps occur.
    wait_n = nsteps * CLK_DIV * pe + (CLK_DIV * pe) / 2;
    for (int i = 0; i < wait_n; i++) begin
      @(negedge clk);
      if (wbm_cycle && first < 0) first = i;
    end
    check("first_write_latency", first, 1);
    enable = 1'b0;
    drain_and_idle(never_ack);
  endtask

  initial begin
    int cnt;
    // Idle after reset: nothing on the bus while disabled.
    idle_noise = 1'b0;
    period = 8'd2;
    do_reset();
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wbm_cycle) cnt++;
    end
    check("no_cycle_while_disabled", cnt, 0);

    run_phase(2'd0, 8'd2, 4'b1010, 1, 4, 1'b0);
    run_phase(2'd3, 8'd1, 4'b1111, 0, 7, 1'b0);
    run_phase(2'd2, 8'd1, 4'b0011, 0, 4, 1'b0);
    idle_noise = 1'b1;
    run_phase(2'd1, 8'd3, 4'b0110, 5, 5, 1'b0);
    run_phase(2'd0, 8'd0, 4'b1001, 2, 6, 1'b0);
    run_phase(2'd0, 8'd5, 4'(4'h1 + ($urandom % 15)), 0, 3, 1'b1);

    // Coalescing: long first ack, two steps with new patterns during the wait.
    idle_noise = 1'b0;
    do_reset();
    mode = 2'd0; period = 8'd1; pattern = 4'h3; ack_delay = 10;
    exp_q.push_back(4'h3);
    repeat (4) exp_q.push_back(4'hC);
    exp_q.push_back(4'h0);
    enable = 1'b1;
    for (int i = 0; i < 6 * CLK_DIV + CLK_DIV / 2; i++) begin
      @(negedge clk);
      if (i == 1) pattern = 4'h9;
      if (i == 4) ack_delay = 0;
      if (i == 8) pattern = 4'hC;
    end
    enable = 1'b0;
    drain_and_idle(1'b0);

    // Reset while a cycle is open: bus drops, nothing recorded.
    do_reset();
    mode = 2'd0; pattern = 4'h5; ack_delay = 1000;
    exp_q.push_back(4'h5);
    enable = 1'b1;
    repeat (5) @(negedge clk);
    check("cycle_before_reset", wbm_cycle, 1);
    reset  = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    check("mid_rst_cycle", wbm_cycle, 0);
    check("mid_rst_write", wbm_write, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cur", cur_leds, 0);
    check("mid_rst_err", err, 0);

    // Randomized runs; ack delays kept short enough that each step is its own write.
    for (int it = 0; it < 10; it++) begin
      logic [1:0] m;
      logic [7:0] p;
      int pe, maxd;
      m  = 2'($urandom % 4);
      p  = 8'($urandom % 4);
      pe = (p == 8'd0) ? 1 : int'(p);
      maxd = (m >= 2'd2) ? CLK_DIV * pe - 4 : CLK_DIV * pe - 2;
      idle_noise = 1'($urandom % 2);
      run_phase(m, p, 4'($urandom), int'($urandom_range(maxd, 0)),
                int'($urandom_range(8, 3)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
